// File: rtl/if_ctrl_pkg.sv
// if_ctrl_pkg: shared state encoding, zero-register constant and default boot length for the fetch controller
package if_ctrl_pkg;
  typedef enum logic [1:0] {BOOT = 2'd0, RUN = 2'd1, MEM_WAIT = 2'd2} state_t;
  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam int DEF_BOOT_CYCLES = 2;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: n-bit up counter (clk, rstb sync active-low, inc) whose output q sticks at all-ones
module sat_counter #(
  parameter int n = 16
) (
  input  logic         clk,
  input  logic         rstb,
  input  logic         inc,
  output logic [n-1:0] q
);
  always_ff @(posedge clk)
    q <= !rstb ? '0 : (inc && !(&q)) ? q + 1'b1 : q;
endmodule

// File: rtl/if_hazard_ctrl.sv
// if_hazard_ctrl: fetch-stage controller; in clk/rstb/dmem_busy/branch_*/ex_*/id_*, out pc_src/pc_target/hold_*/if_flush/id_bubble/stall_cnt/flush_cnt
module if_hazard_ctrl
  import if_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int BOOT_CYCLES = DEF_BOOT_CYCLES,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  rstb,
  input  logic                  dmem_busy,
  input  logic                  branch_taken,
  input  logic [DATA_WIDTH-1:0] branch_target,
  input  logic                  ex_mem_read,
  input  logic [4:0]            ex_rt,
  input  logic [4:0]            id_rs,
  input  logic [4:0]            id_rt,
  output logic                  pc_src,
  output logic [DATA_WIDTH-1:0] pc_target,
  output logic                  hold_pc,
  output logic                  hold_if,
  output logic                  hold_id,
  output logic                  if_flush,
  output logic                  id_bubble,
  output logic [CNT_WIDTH-1:0]  stall_cnt,
  output logic [CNT_WIDTH-1:0]  flush_cnt
);
  state_t                state, state_nxt;
  logic [3:0]            boot_cnt;
  logic                  pend_valid;
  logic [DATA_WIDTH-1:0] pend_target;
  logic                  boot, run, mwait, active, lu, live_br, pend_fire, lu_stall, busy_hold, capture;
  always_comb begin
    boot      = state == BOOT;
    run       = state == RUN;
    mwait     = state == MEM_WAIT;
    active    = run | mwait;
    lu        = ex_mem_read && ex_rt != REG_ZERO && (ex_rt == id_rs || ex_rt == id_rt);
    live_br   = active & !dmem_busy & branch_taken;
    pend_fire = mwait & !dmem_busy & !branch_taken & pend_valid;
    lu_stall  = run & !dmem_busy & !branch_taken & lu;
    busy_hold = active & dmem_busy;
    capture   = busy_hold & branch_taken;
    pc_src    = live_br | pend_fire;
    pc_target = live_br ? branch_target : pend_target;
    hold_pc   = boot | busy_hold | lu_stall;
    hold_if   = busy_hold | lu_stall;
    hold_id   = busy_hold;
    if_flush  = boot | pc_src;
    id_bubble = boot | pc_src | lu_stall;
    state_nxt = boot ? (boot_cnt == 4'd0 ? RUN : BOOT) : dmem_busy ? MEM_WAIT : RUN;
  end
  always_ff @(posedge clk) begin
    if (!rstb) begin
      state       <= BOOT;
      boot_cnt    <= 4'(BOOT_CYCLES - 1);
      pend_valid  <= 1'b0;
      pend_target <= '0;
    end else begin
      state       <= state_nxt;
      boot_cnt    <= boot ? boot_cnt - 4'd1 : boot_cnt;
      pend_valid  <= capture ? 1'b1 : (mwait & !dmem_busy) ? 1'b0 : pend_valid;
      pend_target <= capture ? branch_target : pend_target;
    end
  end
  sat_counter #(.n(CNT_WIDTH)) u_stall_cnt (.clk(clk), .rstb(rstb), .inc(hold_pc & !boot), .q(stall_cnt));
  sat_counter #(.n(CNT_WIDTH)) u_flush_cnt (.clk(clk), .rstb(rstb), .inc(pc_src), .q(flush_cnt));
endmodule

// File: tb/tb_if_hazard_ctrl.sv
// tb_if_hazard_ctrl: directed self-checking bench for if_hazard_ctrl using narrow counters to reach saturation
module tb_if_hazard_ctrl;
  localparam int DW = 32;
  localparam int CW = 4;
  localparam logic [5:0] C_NONE = 6'b000000;
  localparam logic [5:0] C_BOOT = 6'b010011;
  localparam logic [5:0] C_BUSY = 6'b011100;
  localparam logic [5:0] C_LU   = 6'b011001;
  localparam logic [5:0] C_BR   = 6'b100011;
  logic clk = 1'b0, rstb = 1'b0;
  logic dmem_busy = 1'b0, branch_taken = 1'b0, ex_mem_read = 1'b0;
  logic [DW-1:0] branch_target = '0;
  logic [4:0] ex_rt = '0, id_rs = '0, id_rt = '0;
  logic pc_src, hold_pc, hold_if, hold_id, if_flush, id_bubble;
  logic [DW-1:0] pc_target;
  logic [CW-1:0] stall_cnt, flush_cnt;
  logic [5:0] ctl;
  int checks = 0, errors = 0;
  assign ctl = {pc_src, hold_pc, hold_if, hold_id, if_flush, id_bubble};
  always #5 clk = ~clk;
  if_hazard_ctrl #(.DATA_WIDTH(DW), .BOOT_CYCLES(2), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rstb(rstb), .dmem_busy(dmem_busy), .branch_taken(branch_taken),
    .branch_target(branch_target), .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
    .id_rs(id_rs), .id_rt(id_rt), .pc_src(pc_src), .pc_target(pc_target),
    .hold_pc(hold_pc), .hold_if(hold_if), .hold_id(hold_id), .if_flush(if_flush),
    .id_bubble(id_bubble), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );
  task automatic tick();
    @(negedge clk);
    #1;
  endtask
  task automatic clear_inputs();
    dmem_busy = 0; branch_taken = 0; ex_mem_read = 0;
    branch_target = '0; ex_rt = '0; id_rs = '0; id_rt = '0;
  endtask
  task automatic do_reset();
    @(negedge clk);
    clear_inputs(); rstb = 0;
    repeat (2) @(negedge clk);
    rstb = 1;
    repeat (2) @(negedge clk);
  endtask
  task automatic test_reset();
    @(negedge clk);
    clear_inputs(); rstb = 0;
    tick();
    checks++; if (ctl !== C_BOOT) begin errors++; $display("FAIL reset_in ctl=%b exp=%b", ctl, C_BOOT); end
    rstb = 1;
    checks++; if (ctl !== C_BOOT) begin errors++; $display("FAIL boot_c1 ctl=%b exp=%b", ctl, C_BOOT); end
    tick();
    branch_taken = 1; branch_target = 32'h0040_0abc;
    #1;
    checks++; if (ctl !== C_BOOT) begin errors++; $display("FAIL boot_c2_br ctl=%b exp=%b", ctl, C_BOOT); end
    tick();
    branch_taken = 0;
    #1;
    checks++; if (ctl !== C_NONE) begin errors++; $display("FAIL run_after_boot ctl=%b exp=%b", ctl, C_NONE); end
    checks++; if (stall_cnt !== 0 || flush_cnt !== 0) begin errors++; $display("FAIL boot_counters stall=%0d flush=%0d exp=0", stall_cnt, flush_cnt); end
    checks++; if (pc_target !== 0) begin errors++; $display("FAIL boot_target got=%h exp=0", pc_target); end
  endtask
  task automatic test_load_use();
    do_reset();
    ex_mem_read = 1; ex_rt = 5'd8; id_rs = 5'd8;
    #1;
    checks++; if (ctl !== C_LU) begin errors++; $display("FAIL lu_rs ctl=%b exp=%b", ctl, C_LU); end
    tick();
    clear_inputs();
    #1;
    checks++; if (stall_cnt !== 4'd1) begin errors++; $display("FAIL lu_stall_cnt got=%0d exp=1", stall_cnt); end
    checks++; if (ctl !== C_NONE) begin errors++; $display("FAIL lu_one_cycle ctl=%b exp=%b", ctl, C_NONE); end
    ex_mem_read = 1; ex_rt = 5'd0; id_rs = 5'd0; id_rt = 5'd0;
    #1;
    checks++; if (ctl !== C_NONE) begin errors++; $display("FAIL lu_r0 ctl=%b exp=%b", ctl, C_NONE); end
    ex_rt = 5'd9; id_rs = 5'd3; id_rt = 5'd9;
    #1;
    checks++; if (ctl !== C_LU) begin errors++; $display("FAIL lu_rt ctl=%b exp=%b", ctl, C_LU); end
    ex_mem_read = 0;
    #1;
    checks++; if (ctl !== C_NONE) begin errors++; $display("FAIL lu_no_load ctl=%b exp=%b", ctl, C_NONE); end
    tick();
    checks++; if (stall_cnt !== 4'd1) begin errors++; $display("FAIL lu_stall_cnt2 got=%0d exp=1", stall_cnt); end
  endtask
  task automatic test_branch();
    do_reset();
    branch_taken = 1; branch_target = 32'h0040_0100;
    #1;
    checks++; if (ctl !== C_BR) begin errors++; $display("FAIL br_ctl ctl=%b exp=%b", ctl, C_BR); end
    checks++; if (pc_target !== 32'h0040_0100) begin errors++; $display("FAIL br_target got=%h exp=00400100", pc_target); end
    tick();
    clear_inputs();
    #1;
    checks++; if (flush_cnt !== 4'd1) begin errors++; $display("FAIL br_flush_cnt got=%0d exp=1", flush_cnt); end
    checks++; if (ctl !== C_NONE) begin errors++; $display("FAIL br_one_cycle ctl=%b exp=%b", ctl, C_NONE); end
  endtask
  task automatic test_branch_during_wait();
    do_reset();
    dmem_busy = 1;
    #1;
    checks++; if (ctl !== C_BUSY) begin errors++; $display("FAIL bw_c1 ctl=%b exp=%b", ctl, C_BUSY); end
    tick();
    branch_taken = 1; branch_target = 32'h0040_0200;
    #1;
    checks++; if (ctl !== C_BUSY) begin errors++; $display("FAIL bw_c2 ctl=%b exp=%b", ctl, C_BUSY); end
    tick();
    branch_taken = 0; branch_target = '0;
    #1;
    checks++; if (ctl !== C_BUSY) begin errors++; $display("FAIL bw_c3 ctl=%b exp=%b", ctl, C_BUSY); end
    checks++; if (pc_target !== 32'h0040_0200) begin errors++; $display("FAIL bw_pend_tgt got=%h exp=00400200", pc_target); end
    tick();
    checks++; if (ctl !== C_BUSY) begin errors++; $display("FAIL bw_c4 ctl=%b exp=%b", ctl, C_BUSY); end
    tick();
    dmem_busy = 0;
    #1;
    checks++; if (ctl !== C_BR) begin errors++; $display("FAIL bw_redirect ctl=%b exp=%b", ctl, C_BR); end
    checks++; if (pc_target !== 32'h0040_0200) begin errors++; $display("FAIL bw_redirect_tgt got=%h exp=00400200", pc_target); end
    tick();
    checks++; if (ctl !== C_NONE) begin errors++; $display("FAIL bw_run ctl=%b exp=%b", ctl, C_NONE); end
    checks++; if (stall_cnt !== 4'd4 || flush_cnt !== 4'd1) begin errors++; $display("FAIL bw_counters stall=%0d flush=%0d exp=4,1", stall_cnt, flush_cnt); end
  endtask
  task automatic test_last_and_live_win();
    do_reset();
    dmem_busy = 1; branch_taken = 1; branch_target = 32'h0000_1111;
    tick();
    branch_target = 32'h0000_2222;
    tick();
    branch_taken = 0;
    #1;
    checks++; if (pc_target !== 32'h0000_2222) begin errors++; $display("FAIL last_wins got=%h exp=00002222", pc_target); end
    tick();
    dmem_busy = 0; branch_taken = 1; branch_target = 32'h0000_3333;
    #1;
    checks++; if (ctl !== C_BR || pc_target !== 32'h0000_3333) begin errors++; $display("FAIL live_wins ctl=%b tgt=%h exp=%b 00003333", ctl, pc_target, C_BR); end
    tick();
    branch_taken = 0;
    #1;
    checks++; if (ctl !== C_NONE || flush_cnt !== 4'd1) begin errors++; $display("FAIL live_clears ctl=%b flush=%0d exp=%b 1", ctl, flush_cnt, C_NONE); end
    dmem_busy = 1;
    tick();
    dmem_busy = 0;
    #1;
    checks++; if (ctl !== C_NONE) begin errors++; $display("FAIL wait_exit_idle ctl=%b exp=%b", ctl, C_NONE); end
  endtask
  task automatic test_priority();
    do_reset();
    dmem_busy = 1; branch_taken = 1; branch_target = 32'h0040_0300;
    ex_mem_read = 1; ex_rt = 5'd5; id_rs = 5'd5;
    #1;
    checks++; if (ctl !== C_BUSY) begin errors++; $display("FAIL prio_hold ctl=%b exp=%b", ctl, C_BUSY); end
    tick();
    dmem_busy = 0; branch_taken = 0; branch_target = '0;
    #1;
    checks++; if (ctl !== C_BR || pc_target !== 32'h0040_0300) begin errors++; $display("FAIL prio_pend ctl=%b tgt=%h exp=%b 00400300", ctl, pc_target, C_BR); end
    tick();
    checks++; if (ctl !== C_LU) begin errors++; $display("FAIL prio_lu_after ctl=%b exp=%b", ctl, C_LU); end
    clear_inputs();
  endtask
  task automatic test_saturation_and_reset();
    do_reset();
    dmem_busy = 1;
    repeat (18) tick();
    checks++; if (stall_cnt !== 4'hF) begin errors++; $display("FAIL stall_sat got=%h exp=f", stall_cnt); end
    repeat (3) tick();
    checks++; if (stall_cnt !== 4'hF) begin errors++; $display("FAIL stall_sat_hold got=%h exp=f", stall_cnt); end
    dmem_busy = 0;
    tick();
    branch_taken = 1; branch_target = 32'h0000_0040;
    repeat (17) tick();
    checks++; if (flush_cnt !== 4'hF) begin errors++; $display("FAIL flush_sat got=%h exp=f", flush_cnt); end
    branch_taken = 0; dmem_busy = 1;
    tick();
    branch_taken = 1; branch_target = 32'h0040_0400;
    tick();
    branch_taken = 0; rstb = 0;
    tick();
    checks++; if (ctl !== C_BOOT) begin errors++; $display("FAIL rst_wait_ctl ctl=%b exp=%b", ctl, C_BOOT); end
    checks++; if (stall_cnt !== 0 || flush_cnt !== 0) begin errors++; $display("FAIL rst_wait_cnt stall=%0d flush=%0d exp=0", stall_cnt, flush_cnt); end
    rstb = 1; dmem_busy = 0;
    tick();
    checks++; if (ctl !== C_BOOT) begin errors++; $display("FAIL rst_boot2 ctl=%b exp=%b", ctl, C_BOOT); end
    tick();
    checks++; if (ctl !== C_NONE || pc_target !== 0) begin errors++; $display("FAIL no_redirect ctl=%b tgt=%h exp=%b 0", ctl, pc_target, C_NONE); end
    tick();
    checks++; if (flush_cnt !== 0 || stall_cnt !== 0) begin errors++; $display("FAIL post_rst_cnt stall=%0d flush=%0d exp=0", stall_cnt, flush_cnt); end
  endtask
  initial begin
    test_reset();
    test_load_use();
    test_branch();
    test_branch_during_wait();
    test_last_and_live_win();
    test_priority();
    test_saturation_and_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
